flag_branch_unit: RTL and testbench

//  Execute-stage companion to the 16-bit ALU: captures the ALU's raw N/Z/V flags into the

---
 rtl/flag_branch_unit.sv | 89 ++++++++
 tb/tb_flag_branch_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/flag_branch_unit.sv
// Execute-stage flag register with per-opcode update mask, plus branch condition
// resolution against committed or EX-bypassed flags.
module flag_branch_unit #(
    parameter bit BYPASS = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ex_valid,
    input  logic [3:0] ex_op,
    input  logic [2:0] alu_flags,
    input  logic       stall,
    input  logic       flush,
    input  logic       br_valid,
    input  logic [2:0] br_cond,
    output logic [2:0] flags_q,
    output logic       br_taken,
    output logic       flag_stall
);

    typedef enum logic [2:0] {
        C_NEQ    = 3'b000,
        C_EQ     = 3'b001,
        C_GT     = 3'b010,
        C_LT     = 3'b011,
        C_GTE    = 3'b100,
        C_LTE    = 3'b101,
        C_OVFL   = 3'b110,
        C_UNCOND = 3'b111
    } cond_e;

    localparam int N_BIT = 2;
    localparam int Z_BIT = 1;
    localparam int V_BIT = 0;

    logic [2:0] mask;
    logic [2:0] eff_flags;
    logic       ex_live;
    logic       commit;
    logic       cond_met;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        mask = 3'b000;
        case (ex_op)
            4'b0000, 4'b0001:                   mask = 3'b111;
            4'b0010, 4'b0100, 4'b0101, 4'b0110: mask = 3'b010;
            default:                            mask = 3'b000;
        endcase
    end

    assign ex_live = ex_valid & ~flush;
    assign commit  = ex_live & ~stall;

    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 3'b000;
        end else if (commit) begin
            flags_q <= (flags_q & ~mask) | (alu_flags & mask);
        end
    end

    // A stalled EX instruction still forwards: it remains the youngest flag setter.
    always_comb begin
        eff_flags = flags_q;
        if (BYPASS && ex_live) begin
            eff_flags = (flags_q & ~mask) | (alu_flags & mask);
        end
    end

    always_comb begin
        cond_met = 1'b0;
        case (cond_e'(br_cond))
            C_NEQ:    cond_met = ~eff_flags[Z_BIT];
            C_EQ:     cond_met =  eff_flags[Z_BIT];
            C_GT:     cond_met = ~eff_flags[Z_BIT] & ~eff_flags[N_BIT];
            C_LT:     cond_met =  eff_flags[N_BIT];
            C_GTE:    cond_met =  eff_flags[Z_BIT] | ~eff_flags[N_BIT];
            C_LTE:    cond_met =  eff_flags[N_BIT] |  eff_flags[Z_BIT];
            C_OVFL:   cond_met =  eff_flags[V_BIT];
            C_UNCOND: cond_met = 1'b1;
            default:  cond_met = 1'b0;
        endcase
    end

    assign flag_stall = BYPASS ? 1'b0 : (br_valid & ex_live & (|mask));
    assign br_taken   = br_valid & cond_met & ~flag_stall;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: one instance per BYPASS setting, shared stimulus.
module tb_flag_branch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       ex_valid;
    logic [3:0] ex_op;
    logic [2:0] alu_flags;
    logic       stall;
    logic       flush;
    logic       br_valid;
    logic [2:0] br_cond;
    logic [2:0] flags_q1, flags_q0;
    logic       br_taken1, br_taken0;
    logic       flag_stall1, flag_stall0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flag_branch_unit #(.BYPASS(1'b1)) dut_byp (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op), .alu_flags(alu_flags),
        .stall(stall), .flush(flush), .br_valid(br_valid), .br_cond(br_cond),
        .flags_q(flags_q1), .br_taken(br_taken1), .flag_stall(flag_stall1)
    );

    flag_branch_unit #(.BYPASS(1'b0)) dut_stl (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op), .alu_flags(alu_flags),
        .stall(stall), .flush(flush), .br_valid(br_valid), .br_cond(br_cond),
        .flags_q(flags_q0), .br_taken(br_taken0), .flag_stall(flag_stall0)
    );

    typedef struct {
        logic       rst;
        logic       ev;
        logic [3:0] op;
        logic [2:0] af;
        logic       st;
        logic       fl;
        logic       bv;
        logic [2:0] bc;
        logic       chk;   // combinational outputs are defined (flags_q not X)
        logic       t1;
        logic       s1;
        logic       t0;
        logic       s0;
        logic [2:0] q;     // expected flags_q after the edge
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic ev, logic [3:0] op, logic [2:0] af,
                                logic st, logic fl, logic bv, logic [2:0] bc, logic chk,
                                logic t1, logic s1, logic t0, logic s0, logic [2:0] q);
        vec_t v;
        v.rst = r;  v.ev = ev; v.op = op; v.af = af; v.st = st; v.fl = fl;
        v.bv = bv;  v.bc = bc; v.chk = chk;
        v.t1 = t1;  v.s1 = s1; v.t0 = t0; v.s0 = s0; v.q = q;
        return v;
    endfunction

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ev, input logic [3:0] op,
                         input logic [2:0] af, input logic st, input logic fl,
                         input logic bv, input logic [2:0] bc);
        rst = r; ex_valid = ev; ex_op = op; alu_flags = af;
        stall = st; flush = fl; br_valid = bv; br_cond = bc;
    endtask

    initial begin
        drive(1'b0, 1'b0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000);

        //              rst ev  op       af      st  fl  bv  bc      chk t1  s1  t0  s0  q
        vecs.push_back(mk(1, 0, 4'b0000, 3'b000, 0, 0, 1, 3'b001, 0,  0, 0, 0, 0, 3'b000)); // reset
        vecs.push_back(mk(0, 0, 4'b0000, 3'b000, 0, 0, 1, 3'b001, 1,  0, 0, 0, 0, 3'b000)); // EQ on 000
        vecs.push_back(mk(0, 1, 4'b0000, 3'b101, 0, 0, 0, 3'b000, 1,  0, 0, 0, 0, 3'b101)); // ADD
        vecs.push_back(mk(0, 1, 4'b0010, 3'b010, 0, 0, 1, 3'b001, 1,  1, 0, 0, 1, 3'b111)); // XOR Z only
        vecs.push_back(mk(1, 1, 4'b0000, 3'b111, 0, 0, 0, 3'b000, 1,  0, 0, 0, 0, 3'b000)); // rst beats commit
        vecs.push_back(mk(0, 1, 4'b0111, 3'b111, 0, 0, 1, 3'b110, 1,  0, 0, 0, 0, 3'b000)); // PADDSB
        vecs.push_back(mk(0, 1, 4'b0011, 3'b111, 0, 0, 1, 3'b111, 1,  1, 0, 1, 0, 3'b000)); // RED, UNCOND
        vecs.push_back(mk(0, 1, 4'b1010, 3'b111, 0, 0, 1, 3'b011, 1,  0, 0, 0, 0, 3'b000)); // 1xxx, LT
        vecs.push_back(mk(0, 1, 4'b0001, 3'b010, 0, 0, 1, 3'b001, 1,  1, 0, 0, 1, 3'b010)); // SUB bypass
        vecs.push_back(mk(0, 0, 4'b0000, 3'b000, 0, 0, 1, 3'b001, 1,  1, 0, 1, 0, 3'b010)); // bubble
        vecs.push_back(mk(0, 1, 4'b0000, 3'b101, 0, 1, 1, 3'b001, 1,  1, 0, 1, 0, 3'b010)); // flush
        vecs.push_back(mk(0, 1, 4'b0000, 3'b101, 1, 0, 1, 3'b000, 1,  1, 0, 0, 1, 3'b010)); // stall, NEQ
        vecs.push_back(mk(0, 1, 4'b0000, 3'b101, 0, 0, 0, 3'b000, 1,  0, 0, 0, 0, 3'b101)); // release
        vecs.push_back(mk(0, 0, 4'b0000, 3'b010, 0, 0, 1, 3'b010, 1,  0, 0, 0, 0, 3'b101)); // GT
        vecs.push_back(mk(0, 0, 4'b0000, 3'b010, 0, 0, 1, 3'b100, 1,  0, 0, 0, 0, 3'b101)); // GTE
        vecs.push_back(mk(0, 0, 4'b0000, 3'b010, 0, 0, 1, 3'b101, 1,  1, 0, 1, 0, 3'b101)); // LTE
        vecs.push_back(mk(0, 0, 4'b0000, 3'b010, 0, 0, 1, 3'b110, 1,  1, 0, 1, 0, 3'b101)); // OVFL
        vecs.push_back(mk(0, 1, 4'b0100, 3'b010, 0, 0, 1, 3'b001, 1,  1, 0, 0, 1, 3'b111)); // SLL
        vecs.push_back(mk(0, 1, 4'b0001, 3'b000, 1, 1, 1, 3'b100, 1,  1, 0, 1, 0, 3'b111)); // stall+flush
        vecs.push_back(mk(0, 1, 4'b0101, 3'b000, 0, 0, 0, 3'b000, 1,  0, 0, 0, 0, 3'b101)); // SRA
        vecs.push_back(mk(0, 1, 4'b0110, 3'b111, 0, 0, 0, 3'b000, 1,  0, 0, 0, 0, 3'b111)); // ROR
        vecs.push_back(mk(0, 0, 4'b0000, 3'b000, 0, 0, 0, 3'b111, 1,  0, 0, 0, 0, 3'b111)); // br_valid=0

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].ev, vecs[i].op, vecs[i].af,
                  vecs[i].st, vecs[i].fl, vecs[i].bv, vecs[i].bc);
            #1;
            if (vecs[i].chk) begin
                check($sformatf("v%0d br_taken byp", i),   {2'b00, br_taken1},   {2'b00, vecs[i].t1});
                check($sformatf("v%0d flag_stall byp", i), {2'b00, flag_stall1}, {2'b00, vecs[i].s1});
                check($sformatf("v%0d br_taken stl", i),   {2'b00, br_taken0},   {2'b00, vecs[i].t0});
                check($sformatf("v%0d flag_stall stl", i), {2'b00, flag_stall0}, {2'b00, vecs[i].s0});
            end
            @(posedge clk);
            #1;
            check($sformatf("v%0d flags_q byp", i), flags_q1, vecs[i].q);
            check($sformatf("v%0d flags_q stl", i), flags_q0, vecs[i].q);
        end

        // Multi-cycle stall: SUB clearing all flags is held three cycles, then commits once.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 4'b0001, 3'b000, 1'b1, 1'b0, 1'b1, 3'b001);
            #1;
            check($sformatf("hold%0d br_taken byp", c), {2'b00, br_taken1}, 3'b000);
            check($sformatf("hold%0d flag_stall stl", c), {2'b00, flag_stall0}, 3'b001);
            check($sformatf("hold%0d br_taken stl", c), {2'b00, br_taken0}, 3'b000);
            @(posedge clk);
            #1;
            check($sformatf("hold%0d flags_q byp", c), flags_q1, 3'b111);
            check($sformatf("hold%0d flags_q stl", c), flags_q0, 3'b111);
        end
        @(negedge clk);
        drive(1'b0, 1'b1, 4'b0001, 3'b000, 1'b0, 1'b0, 1'b0, 3'b001);
        @(posedge clk);
        #1;
        check("release flags_q byp", flags_q1, 3'b000);
        check("release flags_q stl", flags_q0, 3'b000);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'b0001, 3'b111, 1'b0, 1'b0, 1'b1, 3'b001);
        #1;
        check("after br_taken stl", {2'b00, br_taken0}, 3'b000);
        @(posedge clk);
        #1;
        check("after flags_q byp", flags_q1, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
